// File: rtl/div_radix2_pkg.sv
// div_radix2_pkg: shared state encoding, latency constant and sign helper for the radix-2 divider.
package div_radix2_pkg;

   typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

   // Edges from the accept edge to the edge that raises dout_tvalid.
   localparam int DIV_LATENCY = 34;

   function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
      return n ? -v : v;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// div_radix2: multi-cycle radix-2 restoring divider returning {quotient, remainder}.
module div_radix2 import div_radix2_pkg::*; #(
   parameter int SIGNED = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] s_axis_divisor_tdata,
   input  logic        s_axis_divisor_tvalid,
   output logic        s_axis_divisor_tready,
   input  logic [31:0] s_axis_dividend_tdata,
   input  logic        s_axis_dividend_tvalid,
   output logic        s_axis_dividend_tready,
   output logic [63:0] m_axis_dout_tdata,
   output logic        m_axis_dout_tvalid
);

   localparam bit SG = SIGNED != 0;

   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] dvd, dvs, dvs_abs, rem, quo;
   logic        q_neg, r_neg, acc, ge;
   logic [32:0] sh;
   logic [31:0] sub;

   assign acc = resetn && state == IDLE && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
   assign s_axis_divisor_tready  = acc;
   assign s_axis_dividend_tready = acc;

   // The partial remainder is always below the divisor, so the 32-bit difference is exact.
   assign sh  = {rem, quo[31]};
   assign ge  = sh >= {1'b0, dvs_abs};
   assign sub = sh[31:0] - dvs_abs;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state              <= IDLE;
         cnt                <= '0;
         dvd                <= '0;
         dvs                <= '0;
         dvs_abs            <= '0;
         rem                <= '0;
         quo                <= '0;
         q_neg              <= 1'b0;
         r_neg              <= 1'b0;
         m_axis_dout_tdata  <= '0;
         m_axis_dout_tvalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               m_axis_dout_tvalid <= 1'b0;
               if (acc) begin
                  dvd   <= s_axis_dividend_tdata;
                  dvs   <= s_axis_divisor_tdata;
                  state <= PREP;
               end
            end
            PREP: begin
               dvs_abs <= neg_if(SG && dvs[31], dvs);
               quo     <= neg_if(SG && dvd[31], dvd);
               q_neg   <= SG && (dvd[31] ^ dvs[31]);
               r_neg   <= SG && dvd[31];
               rem     <= '0;
               cnt     <= 5'd31;
               state   <= CALC;
            end
            CALC: begin
               rem   <= ge ? sub : sh[31:0];
               quo   <= {quo[30:0], ge};
               cnt   <= cnt - 5'd1;
               state <= cnt == 5'd0 ? DONE : CALC;
            end
            DONE: begin
               // Divide-by-zero bypasses the sign fix-up entirely.
               m_axis_dout_tdata  <= dvs == '0 ? {32'hFFFF_FFFF, dvd}
                                                : {neg_if(q_neg, quo), neg_if(r_neg, rem)};
               m_axis_dout_tvalid <= 1'b1;
               state              <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: unsigned and signed divider instances checked against table vectors and an arithmetic model.
module tb_div_radix2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] dvs_d = '0, dvd_d = '0;
   logic        vs = 1'b0, vd = 1'b0;
   logic        u_rs, u_rd, s_rs, s_rd, u_v, s_v;
   logic [63:0] u_q, s_q;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   div_radix2 #(.SIGNED(0)) u_dut (
      .clk(clk), .resetn(resetn),
      .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(vs), .s_axis_divisor_tready(u_rs),
      .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(vd), .s_axis_dividend_tready(u_rd),
      .m_axis_dout_tdata(u_q), .m_axis_dout_tvalid(u_v));

   div_radix2 #(.SIGNED(1)) s_dut (
      .clk(clk), .resetn(resetn),
      .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(vs), .s_axis_divisor_tready(s_rs),
      .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(vd), .s_axis_dividend_tready(s_rd),
      .m_axis_dout_tdata(s_q), .m_axis_dout_tvalid(s_v));

   typedef struct {
      logic [31:0] a, b;
      logic [63:0] eu, es;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sg);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (!sg) return {a / b, a % b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      return {32'(sa / sb), 32'(sa % sb)};
   endfunction

   // One operation on both instances. hold keeps both valids high with changing data
   // throughout, so tready must stay low until the result cycle.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                        output logic [63:0] ru, output logic [63:0] rs, output int lat);
      int  w;
      bit  rdy_busy, rdy_end, pair_ok;
      dvd_d = a;
      dvs_d = b;
      vs = 1'b1;
      vd = 1'b1;
      w = 0;
      #1;
      while (!(u_rs && s_rs) && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("accept_wait", 64'(w < 50), 64'd1);
      @(posedge clk);
      #1;
      vs = hold;
      vd = hold;
      dvd_d = $urandom;
      dvs_d = $urandom;
      lat = 0;
      rdy_busy = 1'b0;
      rdy_end = 1'b0;
      pair_ok = 1'b1;
      ru = '0;
      rs = '0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (u_v != s_v) pair_ok = 1'b0;
         if (u_v) begin
            lat = k;
            ru = u_q;
            rs = s_q;
            rdy_end = u_rs && s_rs && u_rd && s_rd;
            break;
         end
         if (u_rs || s_rs || u_rd || s_rd) rdy_busy = 1'b1;
         dvd_d = $urandom;
         dvs_d = $urandom;
      end
      vs = 1'b0;
      vd = 1'b0;
      chk("latency", 64'(lat), 64'd35);
      chk("strobe_pair", 64'(pair_ok), 64'd1);
      if (hold) begin
         chk("tready_low_busy", 64'(rdy_busy), 64'd0);
         chk("tready_high_done", 64'(rdy_end), 64'd1);
      end
      @(negedge clk);
      chk("strobe_one_cycle", {62'd0, u_v, s_v}, 64'd0);
   endtask

   initial begin
      vec_t        tbl[10];
      logic [63:0] ru, rs, hu, hs;
      logic [31:0] a, b;
      int          lat;
      bit          seen;

      tbl[0] = '{32'd100,        32'd7,          64'h0000000E_00000002, 64'h0000000E_00000002};
      tbl[1] = '{32'hFFFF_FFFF,  32'd1,          64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
      tbl[2] = '{32'hFFFF_FFF9,  32'd2,          64'h7FFFFFFC_00000001, 64'hFFFFFFFD_FFFFFFFF};
      tbl[3] = '{32'd7,          32'hFFFF_FFFE,  64'h00000000_00000007, 64'hFFFFFFFD_00000001};
      tbl[4] = '{32'hFFFF_FFF8,  32'hFFFF_FFFC,  64'h00000000_FFFFFFF8, 64'h00000002_00000000};
      tbl[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 64'h80000000_00000000};
      tbl[6] = '{32'd5,          32'd0,          64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005};
      tbl[7] = '{32'hFFFF_FFFB,  32'd0,          64'hFFFFFFFF_FFFFFFFB, 64'hFFFFFFFF_FFFFFFFB};
      tbl[8] = '{32'd9,          32'd3,          64'h00000003_00000000, 64'h00000003_00000000};
      tbl[9] = '{32'd0,          32'd13,         64'h00000000_00000000, 64'h00000000_00000000};

      repeat (3) @(negedge clk);
      chk("reset_dout", u_q | s_q, 64'd0);
      chk("reset_flags", {60'd0, u_v, s_v, u_rs, s_rs}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].a, tbl[i].b, 1'b0, ru, rs, lat);
         chk($sformatf("vec%0d_u", i), ru, tbl[i].eu);
         chk($sformatf("vec%0d_s", i), rs, tbl[i].es);
      end

      // dout holds the last result while idle
      repeat (5) @(negedge clk);
      chk("dout_hold", s_q, tbl[9].es);

      // lone divisor valid is never accepted
      dvs_d = 32'd3;
      dvd_d = 32'd12;
      vs = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("lone_valid_%0d", k), {60'd0, u_rs, u_rd, s_rs, s_rd}, 64'd0);
      end
      vd = 1'b1;
      #1;
      chk("joint_ready", {60'd0, u_rs, u_rd, s_rs, s_rd}, 64'hF);
      vs = 1'b0;
      vd = 1'b0;
      @(negedge clk);

      // valids held high with changing operands: no early accept, result unaffected
      do_op(32'd1000, 32'd33, 1'b1, hu, hs, lat);
      chk("hold_u", hu, model(32'd1000, 32'd33, 1'b0));
      chk("hold_s", hs, model(32'd1000, 32'd33, 1'b1));
      do_op(32'hFFFF_FC18, 32'd33, 1'b1, hu, hs, lat);
      chk("hold2_s", hs, model(32'hFFFF_FC18, 32'd33, 1'b1));

      // reset in the middle of CALC discards the operation
      dvd_d = 32'd100;
      dvs_d = 32'd7;
      vs = 1'b1;
      vd = 1'b1;
      @(posedge clk);
      #1;
      vs = 1'b0;
      vd = 1'b0;
      repeat (12) @(negedge clk);
      resetn = 1'b0;
      vs = 1'b1;
      vd = 1'b1;
      @(negedge clk);
      chk("midreset_dout", u_q | s_q, 64'd0);
      chk("midreset_flags", {60'd0, u_v, s_v, u_rs, s_rs}, 64'd0);
      resetn = 1'b1;
      vs = 1'b0;
      vd = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (u_v || s_v) seen = 1'b1;
      end
      chk("midreset_no_strobe", 64'(seen), 64'd0);
      do_op(32'd9, 32'd3, 1'b0, ru, rs, lat);
      chk("after_reset_u", ru, 64'h00000003_00000000);
      chk("after_reset_s", rs, 64'h00000003_00000000);

      // random operands against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = -($urandom_range(1, 15));
            3: b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         do_op(a, b, 1'b0, ru, rs, lat);
         chk($sformatf("rnd%0d_u %h/%h", i, a, b), ru, model(a, b, 1'b0));
         chk($sformatf("rnd%0d_s %h/%h", i, a, b), rs, model(a, b, 1'b1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
